// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port (toward the AXI bridge) between an instruction-side
//   and a data-side requester. Arbitration happens in IDLE only. The winner's
//   request fields are captured into output registers and held for the whole
//   grant. The grant ends on a single-cycle mem_ready pulse. Ties alternate via
//   last_d, so two permanently requesting sides get D, I, D, I ... service.
//
// Handshake (both requesters):
//   A requester raises x_strobe and holds its fields stable until the arbiter
//   samples them on a rising clk edge in IDLE. Once granted, the transaction is
//   committed and runs to mem_ready even if the strobe drops. x_ready is a
//   one-cycle completion pulse, combinationally equal to mem_ready while that
//   side owns the port. The memory side sees mem_access held high for the
//   whole grant and answers with one mem_ready pulse. mem_ready seen in IDLE is
//   ignored.
//
// Ports
//   clk, clrn                         clock, asynchronous active-low reset
//   i_addr, i_strobe                  instruction-side request
//   i_ready, i_rdata                  instruction-side completion / read data
//   d_addr, d_strobe, d_rw, d_size,
//   d_sel, d_wdata                    data-side request
//   d_ready, d_rdata                  data-side completion / read data
//   mem_a, mem_access, mem_write,
//   mem_size, mem_sel, mem_st_data    registered memory-port request
//   mem_ready, mem_data               memory-port completion / read data
//   state_dbg                         current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        clrn,

    input  logic [31:0] i_addr,
    input  logic        i_strobe,
    output logic        i_ready,
    output logic [31:0] i_rdata,

    input  logic [31:0] d_addr,
    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,

    output logic [31:0] mem_a,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_st_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,

    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0] state;
    logic       last_d;
    logic       pick_d;

    // D wins unless I is also asking and D was served last.
    assign pick_d = d_strobe && (!i_strobe || !last_d);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            mem_access  <= 1'b0;
            mem_write   <= 1'b0;
            mem_a       <= 32'd0;
            mem_size    <= 2'd0;
            mem_sel     <= 4'd0;
            mem_st_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state       <= GRANT_D;
                        mem_access  <= 1'b1;
                        mem_a       <= d_addr;
                        mem_write   <= d_rw;
                        mem_size    <= d_size;
                        mem_sel     <= d_sel;
                        mem_st_data <= d_wdata;
                    end else if (i_strobe) begin
                        // Instruction fetches are always full-word reads.
                        state       <= GRANT_I;
                        mem_access  <= 1'b1;
                        mem_a       <= i_addr;
                        mem_write   <= 1'b0;
                        mem_size    <= 2'b10;
                        mem_sel     <= 4'b1111;
                        mem_st_data <= 32'd0;
                    end
                end
                GRANT_I: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_access <= 1'b0;
                        last_d     <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_access <= 1'b0;
                        last_d     <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_access <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready   = (state == GRANT_I) && mem_ready;
    assign d_ready   = (state == GRANT_D) && mem_ready;
    assign i_rdata   = mem_data;
    assign d_rdata   = mem_data;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        clrn;
    logic [31:0] i_addr;
    logic        i_strobe;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic [31:0] d_addr;
    logic        d_strobe;
    logic        d_rw;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fails  = 0;

    mem_arbiter dut (
        .clk(clk), .clrn(clrn),
        .i_addr(i_addr), .i_strobe(i_strobe), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_addr(d_addr), .d_strobe(d_strobe), .d_rw(d_rw), .d_size(d_size),
        .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_ready(mem_ready), .mem_data(mem_data), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // The port is either free or owned by one side with a captured request.
    typedef struct {
        int          owner;   // 0 free, 1 instruction, 2 data
        logic [31:0] a;
        logic        write;
        logic [1:0]  size;
        logic [3:0]  sel;
        logic [31:0] st_data;
    } txn_t;

    txn_t m_cur;
    bit   m_last_was_d;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_cur        <= '{0, 32'd0, 1'b0, 2'd0, 4'd0, 32'd0};
            m_last_was_d <= 1'b0;
        end else if (m_cur.owner == 0) begin
            if (d_strobe && !(i_strobe && m_last_was_d))
                m_cur <= '{2, d_addr, d_rw, d_size, d_sel, d_wdata};
            else if (i_strobe)
                m_cur <= '{1, i_addr, 1'b0, 2'b10, 4'hF, 32'd0};
        end else if (mem_ready) begin
            m_last_was_d <= (m_cur.owner == 2);
            m_cur.owner  <= 0;
        end
    end

    bit model_en = 1'b0;

    always @(negedge clk) begin
        if (model_en) begin
            check("model mem_access", {31'd0, mem_access}, {31'd0, m_cur.owner != 0});
            check("model i_ready", {31'd0, i_ready}, {31'd0, (m_cur.owner == 1) && mem_ready});
            check("model d_ready", {31'd0, d_ready}, {31'd0, (m_cur.owner == 2) && mem_ready});
            check("model i_rdata", i_rdata, mem_data);
            check("model d_rdata", d_rdata, mem_data);
            if (m_cur.owner != 0) begin
                check("model mem_a", mem_a, m_cur.a);
                check("model mem_write", {31'd0, mem_write}, {31'd0, m_cur.write});
                check("model mem_size", {30'd0, mem_size}, {30'd0, m_cur.size});
                check("model mem_sel", {28'd0, mem_sel}, {28'd0, m_cur.sel});
                check("model mem_st_data", mem_st_data, m_cur.st_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_strobe = 1'b0; d_strobe = 1'b0; mem_ready = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_rw = 1'b0; d_size = 2'd0;
        d_sel = 4'd0; d_wdata = 32'd0; mem_data = 32'd0;
    endtask

    task automatic apply_reset();
        clrn = 1'b0;
        tick();
        tick();
        #2 clrn = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] contention_a [4];

    initial begin
        contention_a[0] = 32'h200; contention_a[1] = 32'h100;
        contention_a[2] = 32'h200; contention_a[3] = 32'h100;
        idle_inputs();
        clrn = 1'b1;
        #3;
        apply_reset();
        model_en = 1'b1;
        #1;
        check("reset mem_access", {31'd0, mem_access}, 32'd0);
        check("reset mem_a", mem_a, 32'd0);
        check("reset mem_sel", {28'd0, mem_sel}, 32'd0);

        // I-fetch: 3-cycle memory latency
        i_strobe = 1'b1; i_addr = 32'hBFC0_0000;
        tick();
        i_strobe = 1'b0;
        check("ifetch mem_access", {31'd0, mem_access}, 32'd1);
        check("ifetch mem_a", mem_a, 32'hBFC0_0000);
        check("ifetch mem_size", {30'd0, mem_size}, 32'd2);
        check("ifetch mem_sel", {28'd0, mem_sel}, 32'hF);
        check("ifetch mem_write", {31'd0, mem_write}, 32'd0);
        tick();
        tick();
        mem_ready = 1'b1; mem_data = 32'h3C1D_0000;
        #1;
        check("ifetch i_ready", {31'd0, i_ready}, 32'd1);
        check("ifetch i_rdata", i_rdata, 32'h3C1D_0000);
        check("ifetch d_ready", {31'd0, d_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        check("ifetch i_ready after", {31'd0, i_ready}, 32'd0);
        check("ifetch idle", {31'd0, mem_access}, 32'd0);

        // D-store
        d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h8000_1004;
        d_size = 2'b00; d_sel = 4'b0010; d_wdata = 32'h0000_AB00;
        tick();
        d_strobe = 1'b0;
        check("dstore mem_write", {31'd0, mem_write}, 32'd1);
        check("dstore mem_a", mem_a, 32'h8000_1004);
        check("dstore mem_size", {30'd0, mem_size}, 32'd0);
        check("dstore mem_sel", {28'd0, mem_sel}, 32'h2);
        check("dstore mem_st_data", mem_st_data, 32'h0000_AB00);
        tick();
        mem_ready = 1'b1;
        #1;
        check("dstore d_ready", {31'd0, d_ready}, 32'd1);
        check("dstore i_ready", {31'd0, i_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        check("dstore idle", {31'd0, mem_access}, 32'd0);

        // Contention from reset: D, I, D, I with one idle cycle between
        idle_inputs();
        apply_reset();
        i_strobe = 1'b1; i_addr = 32'h100;
        d_strobe = 1'b1; d_addr = 32'h200; d_sel = 4'hF; d_size = 2'b10;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("contend grant", {31'd0, mem_access}, 32'd1);
            check("contend mem_a", mem_a, contention_a[g]);
            tick();
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            check("contend idle gap", {31'd0, mem_access}, 32'd0);
        end
        idle_inputs();
        tick();

        // Input-change immunity during a D grant (last served was I)
        d_strobe = 1'b1; d_addr = 32'h300; d_rw = 1'b0; d_sel = 4'hF; d_size = 2'b10;
        tick();
        d_addr = 32'hFFFF_FFFF; d_strobe = 1'b0;
        tick();
        check("immune mem_a", mem_a, 32'h300);
        mem_ready = 1'b1;
        #1;
        check("immune d_ready", {31'd0, d_ready}, 32'd1);
        tick();
        mem_ready = 1'b0;
        idle_inputs();
        tick();

        // Reset two cycles into a D grant
        d_strobe = 1'b1; d_addr = 32'h400; d_rw = 1'b1; d_sel = 4'h3; d_size = 2'b01;
        tick();
        d_strobe = 1'b0;
        tick();
        #2 clrn = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("midreset mem_access", {31'd0, mem_access}, 32'd0);
        check("midreset d_ready", {31'd0, d_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        #2 clrn = 1'b1;
        i_strobe = 1'b1; i_addr = 32'h500;
        tick();
        i_strobe = 1'b0;
        check("postreset grant", {31'd0, mem_access}, 32'd1);
        check("postreset mem_a", mem_a, 32'h500);
        check("postreset mem_write", {31'd0, mem_write}, 32'd0);
        mem_ready = 1'b1;
        #1;
        check("postreset i_ready", {31'd0, i_ready}, 32'd1);
        tick();
        mem_ready = 1'b0;

        // Spurious mem_ready in IDLE
        tick();
        mem_ready = 1'b1;
        #1;
        check("spurious i_ready", {31'd0, i_ready}, 32'd0);
        check("spurious d_ready", {31'd0, d_ready}, 32'd0);
        tick();
        check("spurious stays idle", {31'd0, mem_access}, 32'd0);
        tick();
        mem_ready = 1'b0;
        check("spurious stays idle 2", {31'd0, mem_access}, 32'd0);
        tick();
        tick();

        model_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Port clk  in  1  — single clock; all state updates on its rising edge.
REQ-002 Port clrn  in  1  — asynchronous, active-low reset.
REQ-003 Instruction-side request ports, all in:
- i_addr, 32 bits — instruction-side miss address.
- i_strobe, 1 bit — instruction-side request.
REQ-004 Instruction-side response ports, all out:
- i_ready, 1 bit — instruction-side completion pulse.
- i_rdata, 32 bits — instruction-side read data.
REQ-005 Data-side request ports, all in:
- d_addr, 32 bits.
- d_strobe, 1 bit — data-side request.
- d_rw, 1 bit — 0 read, 1 write.
- d_size, 2 bits — transfer size.
- d_sel, 4 bits — byte strobes.
- d_wdata, 32 bits — store data.
REQ-006 Data-side response ports, all out:
- d_ready, 1 bit — data-side completion pulse.
- d_rdata, 32 bits — data-side read data.
REQ-007 Memory-port outputs toward the AXI interface, all out:
- mem_a, 32 bits.
- mem_access, 1 bit.
- mem_write, 1 bit.
- mem_size, 2 bits.
- mem_sel, 4 bits.
- mem_st_data, 32 bits.
REQ-008 Memory-port inputs: mem_ready  in  1  — completion pulse; mem_data  in  32  — read data.

Function
REQ-009 The FSM SHALL have exactly three states:
- IDLE.
- GRANT_I.
- GRANT_D.
REQ-010 The last_d register (1 bit) SHALL record whether the most recently completed grant was data-side.
REQ-011 IDLE arbitration SHALL be:
- d_strobe=1 and (i_strobe=0 or last_d=0) -> GRANT_D.
- Else i_strobe=1 -> GRANT_I.
- Else stay in IDLE.
REQ-012 On the IDLE->GRANT_x edge, all fields of the winning requester SHALL be latched into output registers.
REQ-013 For an I grant the latched values SHALL be:
- mem_a=i_addr, mem_write=0, mem_size=2'b10, mem_sel=4'b1111.
- mem_st_data=0.
REQ-014 For a D grant the latched values SHALL be: mem_a=d_addr, mem_write=d_rw, mem_size=d_size, mem_sel=d_sel, mem_st_data=d_wdata.
REQ-015 mem_access SHALL be registered: 1 exactly while in GRANT_I or GRANT_D, 0 in IDLE.
REQ-016 The first mem_access cycle SHALL be the cycle after the strobe is sampled (1-cycle arbitration latency).
REQ-017 All mem_* outputs SHALL stay constant for the entire grant, independent of requester inputs.
REQ-018 In GRANT_I, i_ready SHALL equal mem_ready (combinational); in GRANT_D, d_ready SHALL equal mem_ready.
REQ-019 A ready output SHALL be 0 in every other state.
REQ-020 i_rdata and d_rdata SHALL both pass mem_data through unregistered at all times.
REQ-021 On mem_ready=1 in GRANT_x, the next state SHALL be IDLE.
REQ-022 On the same mem_ready=1 edge, last_d SHALL load 1 for GRANT_D and 0 for GRANT_I.
REQ-023 There SHALL be exactly one IDLE cycle between consecutive grants; back-to-back throughput is one transaction per (memory latency + 1) cycles.
REQ-024 mem_ready=1 while in IDLE SHALL be ignored: no ready pulse, no state change.
REQ-025 A strobe that drops while its grant is active SHALL NOT abort the transaction: it runs to mem_ready and the ready pulse is still issued.
REQ-026 Strobe changes by the non-granted requester during a grant SHALL have no effect until IDLE.
REQ-027 With both strobes held high continuously, grants SHALL alternate D, I, D, I..., starting with D after reset.

Reset
REQ-028 clrn=0 SHALL immediately force, without waiting for clk:
- state=IDLE, last_d=0.
- mem_access=0, mem_write=0.
- mem_a=0, mem_size=0, mem_sel=0, mem_st_data=0.
REQ-029 Reset asserted mid-grant SHALL abandon the transaction with no ready pulse.
REQ-030 The first arbitration SHALL occur on the first rising clk edge after clrn returns high.

Verification
REQ-031 I-fetch: i_strobe=1, i_addr=0xBFC00000, memory returns 0x3C1D0000 after 3 cycles -> check:
- mem_access=1 from cycle 1.
- mem_a=0xBFC00000, mem_size=2'b10, mem_sel=4'hF, mem_write=0.
- i_ready pulses 1 cycle with i_rdata=0x3C1D0000; d_ready stays 0.
REQ-032 D-store: d_strobe=1, d_rw=1, d_addr=0x80001004, d_size=2'b00, d_sel=4'b0010, d_wdata=0x0000AB00 -> check:
- mem_write=1 and all fields as given.
- d_ready pulses on mem_ready.
- The next cycle mem_access=0.
REQ-033 Contention: both strobes high from reset, addresses 0x100 (I) and 0x200 (D) -> check:
- mem_a sequence 0x200, 0x100, 0x200, 0x100.
- Each grant separated by exactly one IDLE cycle.
REQ-034 Input-change immunity: during a D grant, change d_addr to 0xFFFFFFFF and drop d_strobe -> check:
- mem_a stays at the latched value.
- d_ready is still asserted on mem_ready.
REQ-035 Reset mid-grant: assert clrn=0 two cycles into a D grant -> check:
- mem_access=0 asynchronously, no ready pulse.
- After release with only i_strobe=1, the first grant is I.
REQ-036 Spurious ready: mem_ready=1 in IDLE with no strobes -> i_ready=d_ready=0 and the state remains IDLE.
